// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// One op in flight: grant/latch, ISSUE, CAPTURE, DONE; result held until the next capture.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       sel0,
    input  logic [2:0]       sel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [1:0]       alu_op,
    output logic             alu_mode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_Cout,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result_out,
    output logic             cout_out,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
    logic [1:0]       op_q;
    logic             mode_q, cout_q;
    logic             grant;
    logic             win;

    // Contention goes to the rr side; a lone requester always wins.
    assign grant = (state_q == IDLE) && (req0 || req1);
    assign win   = (req0 && req1) ? rr_q : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    owner_d = win;
                    rr_d    = ~win;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        busy  = (state_q != IDLE);
        // Reset overrides requests and in-flight completion in the same cycle.
        if (!rst) begin
            gnt0  = grant && !win;
            gnt1  = grant && win;
            done0 = (state_q == DONE) && !owner_q;
            done1 = (state_q == DONE) && owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            op_q     <= 2'b00;
            mode_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            if (grant) begin
                alu_a_q <= win ? a1 : a0;
                alu_b_q <= win ? b1 : b0;
                op_q    <= win ? sel1[1:0] : sel0[1:0];
                mode_q  <= win ? sel1[2] : sel0[2];
            end
            if (state_q == CAPTURE) begin
                result_q <= alu_result;
                cout_q   <= alu_Cout;
            end
        end
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_op     = op_q;
    assign alu_mode   = mode_q;
    assign result_out = result_q;
    assign cout_out   = cout_q;
endmodule
